// File: rtl/as65x_timer_pkg.sv
// Shared constants and types for the AS65X dual 16-bit interval timer.
package as65x_timer_pkg;

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 16;
   localparam int unsigned AW = 3;

   localparam logic [AW-1:0] ADDR_TALO = 3'd0;
   localparam logic [AW-1:0] ADDR_TAHI = 3'd1;
   localparam logic [AW-1:0] ADDR_TBLO = 3'd2;
   localparam logic [AW-1:0] ADDR_TBHI = 3'd3;
   localparam logic [AW-1:0] ADDR_ICR  = 3'd4;
   localparam logic [AW-1:0] ADDR_CRA  = 3'd5;
   localparam logic [AW-1:0] ADDR_CRB  = 3'd6;

   localparam int unsigned CR_START   = 0;
   localparam int unsigned CR_ONESHOT = 3;
   localparam int unsigned CR_LOAD    = 4;
   localparam int unsigned CR_INMODE  = 5;
   localparam int unsigned ICR_SETCLR = 7;

   localparam logic [CW-1:0] LATCH_RST = 16'hFFFF;
   localparam logic [CW-1:0] CNT_RST   = 16'hFFFF;

   typedef struct packed {
      logic inmode;
      logic oneshot;
      logic start;
   } cr_t;

   localparam cr_t CR_RST = '0;

   // Readback image of a control register; LOAD is a strobe and reads 0.
   function automatic logic [DW-1:0] cr_to_byte(input cr_t cr);
      logic [DW-1:0] b;
      b             = '0;
      b[CR_START]   = cr.start;
      b[CR_ONESHOT] = cr.oneshot;
      b[CR_INMODE]  = cr.inmode;
      return b;
   endfunction

endpackage

// File: rtl/as65x_timer_cnt.sv
// One 16-bit down-counter with reload latch, control bits and underflow pulse.
module as65x_timer_cnt
   import as65x_timer_pkg::*;
#(
   parameter bit HAS_INMODE = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          wr_lo,
   input  logic          wr_hi,
   input  logic          wr_cr,
   input  logic [DW-1:0] d,
   input  logic          tick,
   input  logic          alt_ev,
   output logic [CW-1:0] count,
   output cr_t           cr,
   output logic          uflow_c
);

   logic [CW-1:0] latch;
   logic          ev_c;
   logic          load_c;

   assign ev_c    = cr.start & (cr.inmode ? alt_ev : tick);
   assign load_c  = wr_cr & d[CR_LOAD];
   // LOAD wins over a coincident count event, so no underflow is reported then.
   assign uflow_c = ev_c & ~load_c & (count == '0);

   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         latch <= LATCH_RST;
         count <= CNT_RST;
         cr    <= CR_RST;
      end else begin
         if (wr_lo) latch[DW-1:0]  <= d;
         if (wr_hi) latch[CW-1:DW] <= d;

         if (load_c)                  count <= latch;
         else if (wr_hi && !cr.start) count <= {d, latch[DW-1:0]};
         else if (uflow_c)            count <= latch;
         else if (ev_c)               count <= count - CW'(1);

         if (wr_cr) begin
            cr.start   <= d[CR_START];
            cr.oneshot <= d[CR_ONESHOT];
            cr.inmode  <= HAS_INMODE & d[CR_INMODE];
         end else if (uflow_c && cr.oneshot) begin
            cr.start   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/as65x_timer.sv
// AS65X dual interval timer: two counters, interrupt control and CPU register file.
module as65x_timer
   import as65x_timer_pkg::*;
#(
   parameter bit IRQ_REG = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          bus_en,
   input  logic          cs,
   input  logic [AW-1:0] addr,
   input  logic          rwn,
   input  logic [DW-1:0] d_i,
   output logic [DW-1:0] d_o,
   output logic          d_oe,
   output logic          irq_n
);

   logic          wr_c, rd_c;
   logic [CW-1:0] ta_cnt, tb_cnt;
   cr_t           ta_cr, tb_cr;
   logic          ta_uf_c, tb_uf_c;
   logic [1:0]    flags, mask;
   logic          irq_c, irq_q;
   logic [DW-1:0] rdata_c;

   assign wr_c = bus_en & cs & ~rwn;
   assign rd_c = bus_en & cs & rwn;

   as65x_timer_cnt #(.HAS_INMODE(1'b0)) u_ta (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .wr_lo   (wr_c && addr == ADDR_TALO),
      .wr_hi   (wr_c && addr == ADDR_TAHI),
      .wr_cr   (wr_c && addr == ADDR_CRA),
      .d       (d_i),
      .tick    (tick),
      .alt_ev  (1'b0),
      .count   (ta_cnt),
      .cr      (ta_cr),
      .uflow_c (ta_uf_c)
   );

   // Timer B optionally cascades off timer A underflows.
   as65x_timer_cnt #(.HAS_INMODE(1'b1)) u_tb (
      .clk_i   (clk_i),
      .rst_n   (rst_n),
      .wr_lo   (wr_c && addr == ADDR_TBLO),
      .wr_hi   (wr_c && addr == ADDR_TBHI),
      .wr_cr   (wr_c && addr == ADDR_CRB),
      .d       (d_i),
      .tick    (tick),
      .alt_ev  (ta_uf_c),
      .count   (tb_cnt),
      .cr      (tb_cr),
      .uflow_c (tb_uf_c)
   );

   assign irq_c = |(flags & mask);

   // An ICR read clears flags, but an underflow in the same clock survives.
   always_ff @(posedge clk_i) begin
      if (!rst_n) begin
         flags <= '0;
         mask  <= '0;
         irq_q <= 1'b0;
      end else begin
         flags <= ((rd_c && addr == ADDR_ICR) ? 2'b00 : flags) | {tb_uf_c, ta_uf_c};
         if (wr_c && addr == ADDR_ICR) begin
            if (d_i[ICR_SETCLR]) mask <= mask | d_i[1:0];
            else                 mask <= mask & ~d_i[1:0];
         end
         irq_q <= irq_c;
      end
   end

   always_comb begin
      rdata_c = '0;
      case (addr)
         ADDR_TALO: rdata_c = ta_cnt[DW-1:0];
         ADDR_TAHI: rdata_c = ta_cnt[CW-1:DW];
         ADDR_TBLO: rdata_c = tb_cnt[DW-1:0];
         ADDR_TBHI: rdata_c = tb_cnt[CW-1:DW];
         ADDR_ICR:  rdata_c = {irq_c, 5'b00000, flags};
         ADDR_CRA:  rdata_c = cr_to_byte(ta_cr);
         ADDR_CRB:  rdata_c = cr_to_byte(tb_cr);
         default:   rdata_c = '0;
      endcase
   end

   assign d_oe  = cs & rwn;
   assign d_o   = d_oe ? rdata_c : '0;
   assign irq_n = IRQ_REG ? ~irq_q : ~irq_c;

endmodule

// File: tb/tb_as65x_timer.sv
// Randomized and directed bench for as65x_timer against a behavioural model.
module tb_as65x_timer;

   logic       clk_i;
   logic       rst_n;
   logic       tick;
   logic       bus_en;
   logic       cs;
   logic [2:0] addr;
   logic       rwn;
   logic [7:0] d_i;
   logic [7:0] d_o;
   logic       d_oe;
   logic       irq_n;

   int n_checks;
   int n_fail;

   // Behavioural model state: plain integers, flag/mask bit sets.
   int m_latch [2];
   int m_cnt   [2];
   bit m_start [2];
   bit m_oneshot [2];
   bit m_inmode;
   int m_flags;
   int m_mask;
   bit m_irq_q;

   as65x_timer #(.IRQ_REG(1'b1)) dut (
      .clk_i  (clk_i),
      .rst_n  (rst_n),
      .tick   (tick),
      .bus_en (bus_en),
      .cs     (cs),
      .addr   (addr),
      .rwn    (rwn),
      .d_i    (d_i),
      .d_o    (d_o),
      .d_oe   (d_oe),
      .irq_n  (irq_n)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int t = 0; t < 2; t++) begin
         m_latch[t]   = 65535;
         m_cnt[t]     = 65535;
         m_start[t]   = 1'b0;
         m_oneshot[t] = 1'b0;
      end
      m_inmode = 1'b0;
      m_flags  = 0;
      m_mask   = 0;
      m_irq_q  = 1'b0;
   endfunction

   function automatic int model_rd(input int a);
      case (a)
         0: return m_cnt[0] % 256;
         1: return m_cnt[0] / 256;
         2: return m_cnt[1] % 256;
         3: return m_cnt[1] / 256;
         4: return (((m_flags & m_mask) != 0) ? 128 : 0) + m_flags;
         5: return (m_start[0] ? 1 : 0) + (m_oneshot[0] ? 8 : 0);
         6: return (m_start[1] ? 1 : 0) + (m_oneshot[1] ? 8 : 0) + (m_inmode ? 32 : 0);
         default: return 0;
      endcase
   endfunction

   // One clock of the timer, applied from the register-level rules.
   function automatic void model_clk(input bit tk, input bit be, input bit c,
                                     input int a, input bit r, input int d);
      bit wr;
      bit rd;
      bit uf [2];
      bit ev;
      bit load;
      int nxt;
      wr = be && c && !r;
      rd = be && c && r;
      m_irq_q = (m_flags & m_mask) != 0;
      uf[0] = 1'b0;
      uf[1] = 1'b0;
      for (int t = 0; t < 2; t++) begin
         ev   = m_start[t] && ((t == 1 && m_inmode) ? uf[0] : tk);
         load = wr && a == 5 + t && (d & 16) != 0;
         nxt  = m_cnt[t];
         if (load) nxt = m_latch[t];
         else if (wr && a == 2 * t + 1 && !m_start[t]) nxt = d * 256 + m_latch[t] % 256;
         else if (ev) begin
            if (m_cnt[t] == 0) begin
               uf[t] = 1'b1;
               nxt   = m_latch[t];
            end else begin
               nxt = m_cnt[t] - 1;
            end
         end
         m_cnt[t] = nxt;
         if (wr && a == 2 * t)     m_latch[t] = (m_latch[t] / 256) * 256 + d;
         if (wr && a == 2 * t + 1) m_latch[t] = d * 256 + m_latch[t] % 256;
         if (wr && a == 5 + t) begin
            m_start[t]   = (d & 1) != 0;
            m_oneshot[t] = (d & 8) != 0;
            if (t == 1) m_inmode = (d & 32) != 0;
         end else if (uf[t] && m_oneshot[t]) begin
            m_start[t] = 1'b0;
         end
      end
      if (rd && a == 4) m_flags = 0;
      m_flags = m_flags | (uf[0] ? 1 : 0) | (uf[1] ? 2 : 0);
      if (wr && a == 4) begin
         if ((d & 128) != 0) m_mask = m_mask | (d & 3);
         else                m_mask = m_mask & ~(d & 3);
      end
   endfunction

   // One bus clock; outputs are compared with the model at the falling edge.
   task automatic cyc(input bit tk, input bit be, input bit c, input bit [2:0] a,
                      input bit r, input bit [7:0] d, output bit [7:0] v);
      int exp_d;
      tick = tk; bus_en = be; cs = c; addr = a; rwn = r; d_i = d;
      @(negedge clk_i);
      v     = d_o;
      exp_d = (c && r) ? model_rd(int'(a)) : 0;
      check_eq("d_o", 16'(d_o), 16'(exp_d));
      check_eq("d_oe", 16'(d_oe), 16'(c && r));
      check_eq("irq_n", 16'(irq_n), 16'(!m_irq_q));
      @(posedge clk_i);
      model_clk(tk, be, c, int'(a), r, int'(d));
      #1;
   endtask

   task automatic wr(input bit [2:0] a, input bit [7:0] d);
      bit [7:0] v;
      cyc(1'b0, 1'b1, 1'b1, a, 1'b0, d, v);
   endtask

   task automatic rd(input bit [2:0] a, input bit tk, output bit [7:0] v);
      cyc(tk, 1'b1, 1'b1, a, 1'b1, 8'h00, v);
   endtask

   task automatic ticks(input int n);
      bit [7:0] v;
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, v);
   endtask

   task automatic idle(input int n);
      bit [7:0] v;
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, v);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; tick = 1'b1; bus_en = 1'b1; cs = 1'b0; addr = 3'd0; rwn = 1'b1; d_i = 8'h00;
      repeat (2) @(posedge clk_i);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      bit [7:0] v;
      n_checks = 0;
      n_fail   = 0;
      do_reset();

      // Free-running TA, latch 3: flag on every 4th tick.
      wr(3'd0, 8'h03); wr(3'd1, 8'h00); wr(3'd5, 8'h01);
      for (int k = 0; k < 3; k++) begin
         ticks(3);
         rd(3'd4, 1'b0, v); check_eq("ta_period_pre", 16'(v), 16'h0000);
         ticks(1);
         rd(3'd4, 1'b0, v); check_eq("ta_period_flag", 16'(v), 16'h0001);
      end

      // One-shot, latch 2: single underflow after 3 ticks.
      do_reset();
      wr(3'd0, 8'h02); wr(3'd1, 8'h00); wr(3'd5, 8'h09);
      ticks(2);
      rd(3'd4, 1'b0, v); check_eq("oneshot_pre", 16'(v), 16'h0000);
      ticks(1);
      rd(3'd4, 1'b0, v); check_eq("oneshot_flag", 16'(v), 16'h0001);
      rd(3'd5, 1'b0, v); check_eq("oneshot_cra", 16'(v), 16'h0008);
      ticks(8);
      rd(3'd4, 1'b0, v); check_eq("oneshot_once", 16'(v), 16'h0000);

      // Masked TA interrupt, registered irq_n.
      do_reset();
      wr(3'd4, 8'h81); wr(3'd0, 8'h00); wr(3'd1, 8'h00); wr(3'd5, 8'h01);
      ticks(1);
      idle(1);
      check_eq("irq_low", 16'(irq_n), 16'h0000);
      rd(3'd4, 1'b0, v); check_eq("icr_irq", 16'(v), 16'h0081);
      idle(1);
      check_eq("irq_high", 16'(irq_n), 16'h0001);

      // Underflow in the same clock as the ICR read is not lost.
      rd(3'd4, 1'b1, v); check_eq("race_rd", 16'(v), 16'h0000);
      rd(3'd4, 1'b0, v); check_eq("race_kept", 16'(v), 16'h0081);

      // TB cascaded on TA underflows: TB period 6 ticks.
      do_reset();
      wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd2, 8'h02); wr(3'd3, 8'h00);
      wr(3'd6, 8'h21); wr(3'd5, 8'h01);
      rd(3'd6, 1'b0, v); check_eq("crb_rd", 16'(v), 16'h0021);
      for (int k = 0; k < 2; k++) begin
         ticks(5);
         rd(3'd4, 1'b0, v); check_eq("cascade_pre", 16'(v), 16'h0001);
         ticks(1);
         rd(3'd4, 1'b0, v); check_eq("cascade_tb", 16'(v), 16'h0003);
      end

      // Reset while both timers run.
      wr(3'd4, 8'h83); wr(3'd0, 8'h00); wr(3'd5, 8'h01);
      ticks(7);
      do_reset();
      check_eq("rst_irq_n", 16'(irq_n), 16'h0001);
      ticks(1);
      rd(3'd4, 1'b0, v); check_eq("rst_icr", 16'(v), 16'h0000);
      rd(3'd0, 1'b0, v); check_eq("rst_talo", 16'(v), 16'h00FF);
      rd(3'd1, 1'b0, v); check_eq("rst_tahi", 16'(v), 16'h00FF);
      rd(3'd2, 1'b0, v); check_eq("rst_tblo", 16'(v), 16'h00FF);
      rd(3'd3, 1'b0, v); check_eq("rst_tbhi", 16'(v), 16'h00FF);
      rd(3'd5, 1'b0, v); check_eq("rst_cra", 16'(v), 16'h0000);
      rd(3'd6, 1'b0, v); check_eq("rst_crb", 16'(v), 16'h0000);
      rd(3'd7, 1'b0, v); check_eq("rst_a7", 16'(v), 16'h0000);
      wr(3'd5, 8'h10);
      rd(3'd0, 1'b0, v); check_eq("rst_latch", 16'(v), 16'h00FF);

      // Random traffic, small data values favoured so underflows happen.
      for (int i = 0; i < 4000; i++) begin
         bit       tk, be, c, r;
         bit [2:0] a;
         bit [7:0] d;
         if ($urandom_range(999) == 0) do_reset();
         tk = ($urandom_range(3) != 0);
         be = ($urandom_range(1) != 0);
         c  = ($urandom_range(3) != 0);
         r  = ($urandom_range(1) != 0);
         a  = 3'($urandom_range(7));
         d  = ($urandom_range(1) != 0) ? 8'($urandom_range(3)) : 8'($urandom);
         cyc(tk, be, c, a, r, d, v);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/as65x_timer.md
AS65X_TIMER -- requirements
Module: as65x_timer

Interface
- REQ-001 SHALL have parameter IRQ_REG, default 1, meaning irq_n is driven from a flop (1) or combinationally from ICR state (0).
- REQ-002 SHALL have port clk_i, input, 1, the CPU core clock (same PH0 domain as the CPU wrapper).
- REQ-003 SHALL have port rst_n, input, 1, reset: synchronous, active-low.
- REQ-004 SHALL have port tick, input, 1, one-clock count strobe, one pulse per CPU bus cycle.
- REQ-005 SHALL have port bus_en, input, 1, one-clock bus-cycle qualifier; register access occurs only when bus_en=1.
- REQ-006 SHALL have port cs, input, 1, chip select decoded from CPU A_o.
- REQ-007 SHALL have port addr, input, 3, register offset (A_o[2:0]).
- REQ-008 SHALL have port rwn, input, 1, CPU RWn; 1 = read.
- REQ-009 SHALL have port d_i, input, 8, CPU D_o write data.
- REQ-010 SHALL have port d_o, output, 8, read data to the CPU D_i mux.
- REQ-011 SHALL have port d_oe, output, 1, high when cs=1 and rwn=1.
- REQ-012 SHALL have port irq_n, output, 1, active-low interrupt to the CPU IRQn input.

Function
- REQ-013 SHALL map registers: 0 TALO, 1 TAHI, 2 TBLO, 3 TBHI, 4 ICR, 5 CRA, 6 CRB; 7 reads 0x00, writes ignored.
- REQ-014 SHALL, on TxLO/TxHI write, update the 16-bit latch byte; a TxHI write with timer stopped SHALL also load counter from latch (new high byte included).
- REQ-015 SHALL return the live counter byte on TxLO/TxHI read.
- REQ-016 SHALL implement CRx bits: 0 START, 3 ONESHOT, 4 LOAD (strobe, reads 0), 5 (CRB only) INMODE; all other bits read 0.
- REQ-017 SHALL decrement a started timer by 1 on each tick, or for TB with INMODE=1 on each TA underflow pulse instead.
- REQ-018 SHALL treat counter=0x0000 with a count event as underflow: counter reloads latch, ICR flag (bit0 TA, bit1 TB) sets, one-clock underflow pulse; period = latch+1 events.
- REQ-019 SHALL, on underflow with ONESHOT=1, clear START in the same clock.
- REQ-020 SHALL give LOAD priority over a count event in the same clock: counter = latch, no decrement, no flag.
- REQ-021 SHALL, with latch=0x0000 and started, underflow on every count event.
- REQ-022 SHALL on ICR write: bit7=1 sets mask bits where d_i[1:0]=1; bit7=0 clears them.
- REQ-023 SHALL on ICR read return {IRQ,5'b0,flags[1:0]} with IRQ = |(flags & mask), then clear flags at end of cycle.
- REQ-024 SHALL retain a flag set by an underflow in the same clock as an ICR read (new event not lost; read data shows pre-event value).
- REQ-025 SHALL drive irq_n = ~|(flags & mask), one clock later when IRQ_REG=1.
- REQ-026 SHALL ignore all access when bus_en=0 or cs=0; d_o = 0x00 when d_oe=0.

Reset
- REQ-027 SHALL on rst_n=0 clear latches to 0xFFFF, counters to 0xFFFF, CRA/CRB, flags and mask to 0, irq_n to 1.
- REQ-028 SHALL abort any in-progress count on reset mid-operation; the clock after rst_n rises SHALL not underflow.

Structure
- REQ-029 SHALL place register offsets, CR/ICR bit positions and reset constants in package as65x_timer_pkg.
- REQ-030 SHALL implement each timer as sub-module as65x_timer_cnt (latch, counter, START/ONESHOT, underflow pulse), instantiated twice.

Verification
- REQ-031 SHALL test: latch 0x0003, CRA=0x01, tick every clock -> TA flag sets on 4th tick, and every 4 ticks thereafter.
- REQ-032 SHALL test: CRA=0x09 (one-shot), latch 0x0002 -> single underflow after 3 ticks, CRA reads 0x08 afterwards.
- REQ-033 SHALL test: ICR write 0x81, TA underflow -> irq_n low; ICR read returns 0x81, irq_n returns high.
- REQ-034 SHALL test: underflow coinciding with ICR read -> read returns 0x00, flag bit0 still set on next read (0x81 if masked).
- REQ-035 SHALL test: TA latch 0x0001, TB latch 0x0002, CRB=0x21 -> TB underflows once per 6 ticks.
- REQ-036 SHALL test: rst_n pulsed while counters running -> all registers read reset values, irq_n=1.
